mem_xfer_ctrl: RTL and testbench

Parametrised memory-transfer controller, successor to the fixed-size vector controller on the shared memory interface. On a STRT pulse it walks LEN words from a source region, applies a per-run data transform and writes the results to a destination region. Reads and writes strictly alternate on the memory strobes. Completion is signalled by a one-cycle STOP pulse. The block adds programmable read latency, regions, length and transform modes, plus an abort path.

---
 rtl/mem_xfer_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_xfer_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_xfer_ctrl.sv
// rtl/mem_xfer_ctrl.sv - memory-to-memory transfer controller with read latency, address wrap, data transform and abort
module mem_xfer_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_strt,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [ADDR_W:0]   i_len,
    input  logic [1:0]        i_mode,
    output logic              o_mrd,
    output logic              o_mwr,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_busy,
    output logic              o_stop,
    output logic              o_aborted,
    output logic [ADDR_W:0]   o_xfer_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // WAIT lasts RD_LAT cycles; RDATA is taken on the edge that ends the last one
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W:0]   r_len;
    logic [1:0]        r_mode;
    logic [1:0]        r_wait_cnt;
    logic              r_mrd;
    logic              r_mwr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_busy;
    logic              r_stop;
    logic              r_aborted;
    // doubles as the word index of the word in flight
    logic [ADDR_W:0]   r_xfer_cnt;

    logic [ADDR_W:0]   w_cnt_next;
    logic [ADDR_W-1:0] w_rd_addr_next;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_last;
    logic [DATA_W-1:0] w_xform;

    assign w_cnt_next     = r_xfer_cnt + (ADDR_W + 1)'(1);
    assign w_rd_addr_next = r_src + w_cnt_next[ADDR_W-1:0];
    assign w_wr_addr      = r_dst + r_xfer_cnt[ADDR_W-1:0];
    assign w_last         = (w_cnt_next == r_len);

    // per-run data transform applied to the word arriving on RDATA
    always_comb begin
        w_xform = i_rdata;
        case (r_mode)
            2'd0:    w_xform = i_rdata;
            2'd1:    w_xform = ~i_rdata;
            2'd2:    w_xform = i_rdata + DATA_W'(1);
            default: w_xform = '0;
        endcase
    end

    // transfer sequencer; every output is registered alongside the state it belongs to
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_mode     <= '0;
            r_wait_cnt <= '0;
            r_mrd      <= 1'b0;
            r_mwr      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_stop     <= 1'b0;
            r_aborted  <= 1'b0;
            r_xfer_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_strt) begin
                        r_src      <= i_src;
                        r_dst      <= i_dst;
                        r_len      <= i_len;
                        r_mode     <= i_mode;
                        r_xfer_cnt <= '0;
                        r_aborted  <= 1'b0;
                        if (i_len == '0) begin
                            r_state <= S_DONE;
                            r_stop  <= 1'b1;
                        end else begin
                            r_state <= S_RD;
                            r_busy  <= 1'b1;
                            r_mrd   <= 1'b1;
                            r_addr  <= i_src;
                        end
                    end
                end
                S_RD: begin
                    r_mrd      <= 1'b0;
                    r_wait_cnt <= '0;
                    if (i_abort) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_stop    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_abort) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_stop    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state <= S_WR;
                        r_mwr   <= 1'b1;
                        r_addr  <= w_wr_addr;
                        r_wdata <= w_xform;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 2'd1;
                    end
                end
                S_WR: begin
                    // the write strobe of this cycle completes even when aborting
                    r_mwr      <= 1'b0;
                    r_xfer_cnt <= w_cnt_next;
                    if (i_abort || w_last) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_stop    <= 1'b1;
                        r_aborted <= i_abort;
                    end else begin
                        r_state <= S_RD;
                        r_mrd   <= 1'b1;
                        r_addr  <= w_rd_addr_next;
                    end
                end
                S_DONE: begin
                    r_stop  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_mrd   <= 1'b0;
                    r_mwr   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_stop  <= 1'b0;
                end
            endcase
        end
    end

    assign o_mrd      = r_mrd;
    assign o_mwr      = r_mwr;
    assign o_addr     = r_addr;
    assign o_wdata    = r_wdata;
    assign o_busy     = r_busy;
    assign o_stop     = r_stop;
    assign o_aborted  = r_aborted;
    assign o_xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// tb/tb_mem_xfer_ctrl.sv - self-checking bench for mem_xfer_ctrl at RD_LAT=1 and RD_LAT=3
module tb_mem_xfer_ctrl;

    localparam int DW = 16;
    localparam int AW = 7;
    localparam logic [DW-1:0] POISON = 16'hA5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [1:0]             strt, abort;
    logic [1:0][AW-1:0]     src, dst;
    logic [1:0][AW:0]       len;
    logic [1:0][1:0]        mode;
    logic [1:0]             mrd, mwr, busy, stop, aborted;
    logic [1:0][AW-1:0]     addr;
    logic [1:0][DW-1:0]     wdata, rdata;
    logic [1:0][AW:0]       xcnt;

    logic [DW-1:0] mem   [2][128];
    logic [DW-1:0] rpipe [2][4];

    int n_vec = 0;
    int n_err = 0;

    mem_xfer_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_dut_lat1 (
        .i_clk(clk), .i_rst(rst), .i_strt(strt[0]), .i_abort(abort[0]),
        .i_src(src[0]), .i_dst(dst[0]), .i_len(len[0]), .i_mode(mode[0]),
        .o_mrd(mrd[0]), .o_mwr(mwr[0]), .o_addr(addr[0]), .o_wdata(wdata[0]),
        .i_rdata(rdata[0]), .o_busy(busy[0]), .o_stop(stop[0]),
        .o_aborted(aborted[0]), .o_xfer_cnt(xcnt[0])
    );

    mem_xfer_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) u_dut_lat3 (
        .i_clk(clk), .i_rst(rst), .i_strt(strt[1]), .i_abort(abort[1]),
        .i_src(src[1]), .i_dst(dst[1]), .i_len(len[1]), .i_mode(mode[1]),
        .o_mrd(mrd[1]), .o_mwr(mwr[1]), .o_addr(addr[1]), .o_wdata(wdata[1]),
        .i_rdata(rdata[1]), .o_busy(busy[1]), .o_stop(stop[1]),
        .o_aborted(aborted[1]), .o_xfer_cnt(xcnt[1])
    );

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        if (a == 7'h10) return 16'h00FF;
        if (a == 7'h11) return 16'hFFFF;
        return DW'(a) + 16'd1;
    endfunction

    function automatic logic [DW-1:0] xf(input logic [DW-1:0] v, input logic [1:0] m);
        case (m)
            2'd0:    return v;
            2'd1:    return ~v;
            2'd2:    return v + 16'd1;
            default: return 16'd0;
        endcase
    endfunction

    // memory model: write on MWR, read data appears RD_LAT cycles after MRD, poison otherwise
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            for (int k = 3; k > 0; k--) rpipe[g][k] <= rpipe[g][k-1];
            rpipe[g][0] <= mrd[g] ? mem[g][addr[g]] : POISON;
            if (rst) begin
                for (int a = 0; a < 128; a++) mem[g][a] <= init_word(7'(a));
            end else if (mwr[g]) begin
                mem[g][addr[g]] <= wdata[g];
            end
        end
    end
    assign rdata[0] = rpipe[0][0];
    assign rdata[1] = rpipe[1][2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // behavioural model: expected outputs from cycles-since-start arithmetic and a reference memory
    logic [DW-1:0] refmem [2][128];
    bit            m_valid;
    bit            m_busy [2];
    bit            m_stop [2];
    bit            m_abtd [2];
    int            m_t [2];
    int            m_len [2];
    int            m_cnt [2];
    logic [AW-1:0] m_src [2];
    logic [AW-1:0] m_dst [2];
    logic [1:0]    m_mode [2];

    initial begin
        int lat, per, w, ph;
        bit e_mrd, e_mwr;
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] fv;
        m_valid = 0;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                lat = (g == 0) ? 1 : 3;
                per = lat + 2;
                e_mrd = 0; e_mwr = 0; w = 0; ph = 0;
                if (m_busy[g]) begin
                    w  = (m_t[g] - 1) / per;
                    ph = (m_t[g] - 1) % per;
                    e_mrd = (ph == 0);
                    e_mwr = (ph == lat + 1);
                end
                ra = m_src[g] + AW'(w);
                wa = m_dst[g] + AW'(w);
                fv = xf(refmem[g][ra], m_mode[g]);
                if (m_valid) begin
                    chk($sformatf("dut%0d mrd", g), 32'(mrd[g]), 32'(e_mrd));
                    chk($sformatf("dut%0d mwr", g), 32'(mwr[g]), 32'(e_mwr));
                    chk($sformatf("dut%0d busy", g), 32'(busy[g]), 32'(m_busy[g]));
                    chk($sformatf("dut%0d stop", g), 32'(stop[g]), 32'(m_stop[g]));
                    chk($sformatf("dut%0d aborted", g), 32'(aborted[g]), 32'(m_abtd[g]));
                    chk($sformatf("dut%0d xfer_cnt", g), 32'(xcnt[g]), 32'(m_cnt[g]));
                    if (e_mrd) chk($sformatf("dut%0d rd addr", g), 32'(addr[g]), 32'(ra));
                    if (e_mwr) begin
                        chk($sformatf("dut%0d wr addr", g), 32'(addr[g]), 32'(wa));
                        chk($sformatf("dut%0d wdata", g), 32'(wdata[g]), 32'(fv));
                    end
                end
                if (rst) begin
                    m_valid = 1;
                    m_busy[g] = 0; m_stop[g] = 0; m_abtd[g] = 0;
                    m_t[g] = 0; m_len[g] = 0; m_cnt[g] = 0;
                    m_src[g] = '0; m_dst[g] = '0; m_mode[g] = '0;
                    for (int a = 0; a < 128; a++) refmem[g][a] = init_word(7'(a));
                end else if (m_valid) begin
                    if (m_busy[g]) begin
                        if (e_mwr) begin
                            refmem[g][wa] = fv;
                            m_cnt[g]++;
                        end
                        if (abort[g]) begin
                            m_busy[g] = 0; m_stop[g] = 1; m_abtd[g] = 1;
                        end else if (e_mwr && (w + 1 == m_len[g])) begin
                            m_busy[g] = 0; m_stop[g] = 1;
                        end else begin
                            m_t[g]++;
                        end
                    end else if (m_stop[g]) begin
                        m_stop[g] = 0;
                    end else if (strt[g]) begin
                        m_src[g] = src[g]; m_dst[g] = dst[g];
                        m_len[g] = int'(len[g]); m_mode[g] = mode[g];
                        m_cnt[g] = 0; m_abtd[g] = 0;
                        if (len[g] == '0) m_stop[g] = 1;
                        else begin
                            m_busy[g] = 1; m_t[g] = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic start(input int g, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW:0] l, input logic [1:0] m);
        @(posedge clk); #1;
        strt[g] = 1'b1; src[g] = s; dst[g] = d; len[g] = l; mode[g] = m;
        @(posedge clk); #1;
        strt[g] = 1'b0;
    endtask

    task automatic wait_stop(input int g);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!stop[g] && n < 200);
        chk($sformatf("dut%0d stop seen", g), 32'(stop[g]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [15:0] rm, rw, rs;
        int ns;
        rst = 1'b1; strt = '0; abort = '0; src = '0; dst = '0; len = '0; mode = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("reset busy/strobes/stop/aborted", 32'({mrd[g], mwr[g], busy[g], stop[g], aborted[g]}), 32'd0);
            chk("reset addr", 32'(addr[g]), 32'd0);
            chk("reset wdata", 32'(wdata[g]), 32'd0);
            chk("reset xfer_cnt", 32'(xcnt[g]), 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;

        // basic copy, cycle-exact strobe positions
        rm = '0; rw = '0; rs = '0;
        start(0, 7'h00, 7'h40, 8'd4, 2'd0);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            rm[c] = mrd[0]; rw[c] = mwr[0]; rs[c] = stop[0];
            if (c == 13) begin
                chk("t1 xfer_cnt", 32'(xcnt[0]), 32'd4);
                chk("t1 aborted", 32'(aborted[0]), 32'd0);
            end
        end
        chk("t1 mrd cycles", 32'(rm), 32'h0492);
        chk("t1 mwr cycles", 32'(rw), 32'h1248);
        chk("t1 stop cycles", 32'(rs), 32'h2000);
        for (int i = 0; i < 4; i++) chk("t1 mem", 32'(mem[0][7'h40 + i]), 32'(i + 1));

        // transforms on 0x00FF / 0xFFFF
        start(0, 7'h10, 7'h20, 8'd2, 2'd1); wait_stop(0);
        start(0, 7'h10, 7'h22, 8'd2, 2'd2); wait_stop(0);
        start(0, 7'h10, 7'h24, 8'd2, 2'd3); wait_stop(0);
        chk("invert 00FF", 32'(mem[0][7'h20]), 32'hFF00);
        chk("invert FFFF", 32'(mem[0][7'h21]), 32'h0000);
        chk("incr 00FF", 32'(mem[0][7'h22]), 32'h0100);
        chk("incr FFFF", 32'(mem[0][7'h23]), 32'h0000);
        chk("zero 00FF", 32'(mem[0][7'h24]), 32'h0000);
        chk("zero FFFF", 32'(mem[0][7'h25]), 32'h0000);

        // address wrap with overlapping forward copy
        start(0, 7'h7E, 7'h7F, 8'd3, 2'd0); wait_stop(0);
        chk("wrap mem7F", 32'(mem[0][7'h7F]), 32'h007F);
        chk("wrap mem00", 32'(mem[0][7'h00]), 32'h007F);
        chk("wrap mem01", 32'(mem[0][7'h01]), 32'h007F);

        // zero length
        start(0, 7'h05, 7'h06, 8'd0, 2'd0);
        @(negedge clk);
        chk("len0 stop", 32'(stop[0]), 32'd1);
        chk("len0 strobes/busy", 32'({mrd[0], mwr[0], busy[0]}), 32'd0);
        chk("len0 xfer_cnt", 32'(xcnt[0]), 32'd0);

        // STRT mid-run is ignored
        start(0, 7'h30, 7'h50, 8'd4, 2'd0);
        repeat (3) @(posedge clk);
        #1 strt[0] = 1'b1; src[0] = 7'h60; len[0] = 8'd1;
        @(posedge clk); #1 strt[0] = 1'b0;
        ns = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stop[0]) ns++;
        end
        chk("midrun stop count", 32'(ns), 32'd1);
        chk("midrun xfer_cnt", 32'(xcnt[0]), 32'd4);
        chk("midrun mem50", 32'(mem[0][7'h50]), 32'h0031);
        chk("midrun mem53", 32'(mem[0][7'h53]), 32'h0034);

        // abort in the WAIT of word 2 at RD_LAT=3
        start(1, 7'h00, 7'h40, 8'd5, 2'd0);
        repeat (12) @(posedge clk);
        #1 abort[1] = 1'b1;
        @(posedge clk); #1 abort[1] = 1'b0;
        @(negedge clk);
        chk("abort stop", 32'(stop[1]), 32'd1);
        chk("abort aborted", 32'(aborted[1]), 32'd1);
        chk("abort xfer_cnt", 32'(xcnt[1]), 32'd2);
        chk("abort mem41", 32'(mem[1][7'h41]), 32'h0002);
        chk("abort mem42 untouched", 32'(mem[1][7'h42]), 32'h0043);
        start(1, 7'h00, 7'h48, 8'd1, 2'd0);
        @(negedge clk);
        chk("restart clears aborted", 32'(aborted[1]), 32'd0);
        wait_stop(1);

        // ABORT and STRT together in IDLE: STRT wins
        @(posedge clk); #1;
        strt[1] = 1'b1; abort[1] = 1'b1; src[1] = 7'h02; dst[1] = 7'h70; len[1] = 8'd2; mode[1] = 2'd0;
        @(posedge clk); #1 strt[1] = 1'b0; abort[1] = 1'b0;
        wait_stop(1);
        chk("strt+abort xfer_cnt", 32'(xcnt[1]), 32'd2);
        chk("strt+abort aborted", 32'(aborted[1]), 32'd0);
        chk("strt+abort mem71", 32'(mem[1][7'h71]), 32'h0004);

        // reset during a WR cycle, then a clean run
        start(0, 7'h00, 7'h60, 8'd4, 2'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst in WR cycle", 32'(mwr[0]), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post-rst flags", 32'({mrd[0], mwr[0], busy[0], stop[0], aborted[0]}), 32'd0);
        chk("post-rst addr", 32'(addr[0]), 32'd0);
        chk("post-rst wdata", 32'(wdata[0]), 32'd0);
        chk("post-rst xfer_cnt", 32'(xcnt[0]), 32'd0);
        start(0, 7'h00, 7'h60, 8'd4, 2'd0);
        wait_stop(0);
        chk("post-rst run xfer_cnt", 32'(xcnt[0]), 32'd4);
        chk("post-rst run mem63", 32'(mem[0][7'h63]), 32'h0004);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
